fourphase_rr_arbiter: RTL
=========================

FOURPHASE_RR_ARBITER -- requirements
Module: fourphase_rr_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters (>=2).
REQ-002 Parameter DataWidth, default 32, payload width per requester.
REQ-003 Parameter IdxWidth, default $clog2(NumReq), grant index width (derived, not overridden).
REQ-004 clk_i  input  1  single clock; every port is synchronous to it.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 req_valid_i  input  NumReq  per-requester valid.
REQ-007 req_data_i  input  NumReq x DataWidth  per-requester payload.
REQ-008 req_ready_o  output  NumReq  per-requester ready; one-hot or zero.
REQ-009 hs_req_o  output  1  level 4-phase request toward the shared resource.
REQ-010 hs_ack_i  input  1  level 4-phase acknowledge from the shared resource.
REQ-011 hs_data_o  output  DataWidth  registered payload of the granted requester.
REQ-012 hs_idx_o  output  IdxWidth  registered index of the granted requester.
REQ-013 busy_o  output  1  high whenever state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ and RELEASE.
REQ-015 IDLE -> REQ when any req_valid_i bit is high and hs_ack_i == 0; in that cycle, capture the winner's data into hs_data_o and its index into hs_idx_o.
REQ-016 Winner selection SHALL be round-robin: first valid index at or above rr_ptr, wrapping from NumReq-1 to 0.
REQ-017 IDLE with hs_ack_i == 1 (stale ack) SHALL stay IDLE and grant nothing until hs_ack_i returns to 0.
REQ-018 hs_req_o SHALL be registered and high exactly in state REQ: it rises the cycle after the grant and is low in IDLE and RELEASE.
REQ-019 In REQ with hs_ack_i == 1: req_ready_o[hs_idx_o] SHALL be 1 in that same cycle (combinational from hs_ack_i), the FSM SHALL move to RELEASE, and rr_ptr SHALL become (hs_idx_o+1) mod NumReq.
REQ-020 In REQ with hs_ack_i == 0: hold REQ, keep hs_data_o/hs_idx_o stable, all req_ready_o = 0.
REQ-021 RELEASE -> IDLE when hs_ack_i == 0; otherwise hold RELEASE.
REQ-022 req_ready_o SHALL be nonzero only as stated in REQ-019: exactly one cycle per transaction.
REQ-023 A requester handshake occurs when req_valid_i[i] && req_ready_o[i]; the requester SHALL hold valid and data stable from the grant until that handshake.
REQ-024 The minimum transaction length SHALL be 4 cycles for an ack that responds in one cycle: grant, REQ, RELEASE, IDLE. Back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-025 Changes to req_valid_i while in REQ or RELEASE SHALL NOT affect the current transaction.
REQ-026 rr_ptr SHALL change only on the REQ -> RELEASE transition. It is IdxWidth wide, and wrap-around SHALL use modulo NumReq even when NumReq is not a power of two.
REQ-027 Simulation-only assertions SHALL check: req_valid_i[g] stable high from grant to handshake; hs_ack_i does not rise outside REQ; req_ready_o is onehot0.

Reset
REQ-028 Asserting rst_ni low SHALL asynchronously force: state IDLE, hs_req_o 0, req_ready_o 0, busy_o 0, hs_data_o 0, hs_idx_o 0, rr_ptr 0.
REQ-029 A reset mid-transaction SHALL abandon that transaction; after reset, the stale-ack rule (REQ-017) protects the resource until hs_ack_i is 0.
REQ-030 Leaving reset SHALL be synchronous to clk_i. The first grant can occur in the first clock edge after release.

Verification
REQ-031 Single request: NumReq=4, only valid[2] high at t0, ack responds one cycle after req -> hs_req_o high t1; ack high t2 so ready[2]=1 at t2; hs_req_o 0 at t3; IDLE; hs_idx_o=2, rr_ptr=3.
REQ-032 Fairness: all four valid held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each ready pulses exactly once per round.
REQ-033 Wrap: rr_ptr=3 with valid={0,1} only -> grant 0, then 1, then 0.
REQ-034 Slow ack: ack delayed 10 cycles in REQ and 5 in RELEASE -> hs_req_o high exactly 10 cycles, no ready until ack, hs_data_o stable throughout.
REQ-035 Stale ack: hs_ack_i held high 3 cycles in IDLE with valid[1] high -> no grant, hs_req_o 0; grant occurs the cycle ack falls.
REQ-036 Reset mid-REQ: rst_ni low while hs_req_o=1 -> hs_req_o 0 immediately, no ready pulse. After release with ack still high, the FSM waits for ack=0 before re-granting.

Source files
------------

// File: rtl/fourphase_rr_arbiter.sv
// Round-robin arbiter that forwards one requester's payload to a shared
// resource over a level-sensitive four-phase req/ack handshake.
module fourphase_rr_arbiter #(
    parameter  int NumReq    = 4,
    parameter  int DataWidth = 32,
    localparam int IdxWidth  = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        hs_req_o,
    input  logic                        hs_ack_i,
    output logic [DataWidth-1:0]        hs_data_o,
    output logic [IdxWidth-1:0]         hs_idx_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic                 hs_req_q;
    logic [DataWidth-1:0] hs_data_q;
    logic [IdxWidth-1:0]  hs_idx_q;
    logic [IdxWidth-1:0]  rr_ptr_q;

    logic [DataWidth-1:0] req_data_arr [NumReq];
    logic                 any_valid;
    logic [IdxWidth-1:0]  win_idx;
    logic [IdxWidth-1:0]  cand_idx;
    int                   cand;
    logic                 grant_en;
    logic                 rr_adv;

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign req_data_arr[g] = req_data_i[g*DataWidth +: DataWidth];
    end

    // Search starts at rr_ptr and wraps modulo NumReq, so non-power-of-two
    // requester counts never index past the last requester.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // paths that skip an assignment would infer a latch.
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdxWidth'(cand);
            if (!any_valid && req_valid_i[cand_idx]) begin
                any_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stale ack left over from an abandoned transaction blocks new grants.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (any_valid && !hs_ack_i) state_d = ST_REQ;
            ST_REQ:     if (hs_ack_i)               state_d = ST_RELEASE;
            ST_RELEASE: if (!hs_ack_i)              state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        grant_en    = 1'b0;
        rr_adv      = 1'b0;
        busy_o      = (state_q != ST_IDLE);
        if (state_q == ST_IDLE && any_valid && !hs_ack_i) begin
            grant_en = 1'b1;
        end
        if (state_q == ST_REQ && hs_ack_i) begin
            req_ready_o[hs_idx_q] = 1'b1;
            rr_adv                = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_req_q  <= 1'b0;
            hs_data_q <= '0;
            hs_idx_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            hs_req_q <= (state_d == ST_REQ);
            if (grant_en) begin
                hs_data_q <= req_data_arr[win_idx];
                hs_idx_q  <= win_idx;
            end
            if (rr_adv) begin
                rr_ptr_q <= (hs_idx_q == IdxWidth'(NumReq - 1)) ? '0
                                                                : hs_idx_q + IdxWidth'(1);
            end
        end
    end

    assign hs_req_o  = hs_req_q;
    assign hs_data_o = hs_data_q;
    assign hs_idx_o  = hs_idx_q;

`ifndef SYNTHESIS
    logic ack_prev;

    // Deliberately not reset: an ack held high across reset is not a new edge.
    always_ff @(posedge clk_i) begin
        ack_prev <= hs_ack_i;
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == ST_REQ) begin
                assert (req_valid_i[hs_idx_q])
                else $error("granted requester %0d dropped valid before handshake", hs_idx_q);
            end
            if (hs_ack_i && !ack_prev) begin
                assert (state_q == ST_REQ)
                else $error("hs_ack_i rose outside REQ");
            end
            assert ($onehot0(req_ready_o))
            else $error("req_ready_o not onehot0: %b", req_ready_o);
        end
    end
`endif

endmodule
